fetch_buffer: RTL
=================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the instruction queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, setting the first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port ReqValid  output  1  instruction-memory fetch request.
REQ-006 The block SHALL have port ReqAddr  output  32  word-aligned fetch address.
REQ-007 The block SHALL have port ReqReady  input  1  memory accepts the request this cycle.
REQ-008 The block SHALL have port RespValid  input  1  fetched word valid.
REQ-009 The block SHALL have port RespData  input  32  fetched instruction word.
REQ-010 The block SHALL have port RedirectE  input  1  taken branch/jump; flush and refetch.
REQ-011 The block SHALL have port PCTargetE  input  32  redirect target address.
REQ-012 The block SHALL have port StallD  input  1  decode stage not accepting.
REQ-013 The block SHALL have port ValidD  output  1  head entry valid for decode.
REQ-014 The block SHALL have port InstrD  output  32  head instruction; 32'h0 when ValidD=0.
REQ-015 The block SHALL have port PCD  output  32  PC of head instruction.
REQ-016 The block SHALL have port PCPlus4D  output  32  PCD + 4, modulo 2^32.

Function
REQ-017 The block SHALL hold a circular queue of DEPTH {instr, pc} entries with head/tail pointers and an occupancy count of width clog2(DEPTH)+1.
REQ-018 ReqValid SHALL be high when count + outstanding < DEPTH and RedirectE=0; a request is issued when ReqValid && ReqReady.
REQ-019 At most one request SHALL be outstanding; memory returns RespValid exactly one cycle after acceptance.
REQ-020 On issue, the fetch PC SHALL advance by 4, wrapping from 32'hFFFF_FFFC to 32'h0.
REQ-021 A response SHALL be pushed at the tail with the PC of its request unless it is marked stale.
REQ-022 A pop SHALL occur when ValidD && !StallD; the head advances and count decrements.
REQ-023 A push and pop in the same cycle SHALL leave count unchanged, and this SHALL be legal at full and at empty.
REQ-024 ValidD SHALL equal (count != 0); when empty, InstrD SHALL be 32'h0, which decodes as a bubble with all control outputs zero.
REQ-025 With ReqReady=1, no stall and no redirect, the first instruction after reset SHALL reach ValidD=1 in cycle 2 (issue at cycle 0, response at cycle 1, visible at cycle 2).
REQ-026 On RedirectE=1, the next edge SHALL clear count and pointers, set the fetch PC to PCTargetE, and mark any outstanding request stale; that stale response SHALL be dropped.
REQ-027 RedirectE SHALL override a simultaneous push, pop or stall; ReqValid SHALL be low in the redirect cycle.
REQ-028 PCTargetE[1:0] SHALL be forced to 2'b00.

Reset
REQ-029 While reset_n=0 at a clock edge, the block SHALL set fetch PC to RESET_PC, count, pointers and outstanding to 0, stale to 0, and ValidD to 0.
REQ-030 After reset, InstrD, PCD and PCPlus4D SHALL read 0, 0 and 4; ReqValid SHALL be 1 in the first cycle after reset release.
REQ-031 Reset asserted mid-operation SHALL discard queued and in-flight instructions, with no stale push after release.

Configuration
REQ-032 With macro FETCH_BUFFER_BYPASS_EN defined, a non-stale response arriving while count=0 and StallD=0 SHALL drive ValidD/InstrD/PCD in the same cycle and SHALL NOT be enqueued; first-instruction latency becomes 1 cycle.
REQ-033 Without FETCH_BUFFER_BYPASS_EN, every response SHALL be enqueued first, giving the REQ-025 latency.

Verification
REQ-034 Reset release, ReqReady=1, words 0x00500093, 0x00100113 -> ReqAddr 0x0, 0x4; cycle 2: ValidD=1, InstrD=0x00500093, PCD=0, PCPlus4D=4.
REQ-035 StallD=1 held for 10 cycles, DEPTH=4 -> count saturates at 4, ReqValid=0, no push; StallD=0 -> pops in order, PCD 0x0, 0x4, 0x8, 0xC.
REQ-036 RedirectE=1, PCTargetE=0x100 while a request to 0x10 is outstanding -> next cycle ValidD=0; response for 0x10 dropped; next ReqAddr=0x100; first ValidD shows PCD=0x100.
REQ-037 Push and pop in the same cycle at count=4 and at count=0 -> count unchanged at 4; at 0 the word is accepted, with no loss or duplication.
REQ-038 ReqReady toggled randomly 1000 cycles, StallD random -> instruction stream in PC order, PCD consecutive +4, no gaps.
REQ-039 reset_n=0 asserted for 1 cycle with 3 entries queued -> ValidD=0, ReqAddr=RESET_PC next cycle; FETCH_BUFFER_BYPASS_EN build -> first ValidD in cycle 1.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch request generator feeding a DEPTH-entry {instr, pc} queue for decode.
// Define FETCH_BUFFER_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ReqValid,
    output logic [31:0] ReqAddr,
    input  logic        ReqReady,
    input  logic        RespValid,
    input  logic [31:0] RespData,
    input  logic        RedirectE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0] instr_q [DEPTH];
    logic [31:0] instr_d [DEPTH];
    logic [31:0] pc_buf_q [DEPTH];
    logic [31:0] pc_buf_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0] count_q, count_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic outstanding_q, outstanding_d, stale_q, stale_d;
    logic issue, resp_ok, bypass, push, pop;

    always_comb begin
        ReqValid = (count_q + (AW+1)'(outstanding_q)) < DEPTH_C && !RedirectE;
        ReqAddr = fetch_pc_q;
        issue = ReqValid && ReqReady;
        resp_ok = RespValid && outstanding_q && !stale_q && !RedirectE;
`ifdef FETCH_BUFFER_BYPASS_EN
        bypass = resp_ok && count_q == '0 && !StallD;
`else
        bypass = 1'b0;
`endif
        push = resp_ok && !bypass;
        pop = count_q != '0 && !StallD && !RedirectE;
        ValidD = count_q != '0 || bypass;
        InstrD = bypass ? RespData : ValidD ? instr_q[head_q] : 32'h0;
        PCD = bypass ? req_pc_q : ValidD ? pc_buf_q[head_q] : 32'h0;
        PCPlus4D = PCD + 32'd4;
        instr_d = instr_q;
        pc_buf_d = pc_buf_q;
        if (push) begin
            instr_d[tail_q] = RespData;
            pc_buf_d[tail_q] = req_pc_q;
        end
        head_d = RedirectE ? '0 : head_q + AW'(pop);
        tail_d = RedirectE ? '0 : tail_q + AW'(push);
        count_d = RedirectE ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        fetch_pc_d = RedirectE ? {PCTargetE[31:2], 2'b00} : issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        req_pc_d = issue ? fetch_pc_q : req_pc_q;
        outstanding_d = issue || (outstanding_q && !RespValid);
        // a request still in flight across a redirect must have its response discarded
        stale_d = (RedirectE || stale_q) && outstanding_q && !RespValid;
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_buf_q <= pc_buf_d;
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            fetch_pc_q <= RESET_PC;
            req_pc_q <= 32'h0;
            outstanding_q <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q <= req_pc_d;
            outstanding_q <= outstanding_d;
            stale_q <= stale_d;
        end
    end
endmodule
